// File: rtl/alu_iter.sv
// Registered execute-stage ALU: single-cycle logic/arith/shift ops, plus 1-bit/cycle multiply and divide.
// Single-cycle ops give a result 1 cycle after accept. Iterative ops take RW cycles with o_ready low; i_flush aborts.
module alu_iter #(
    parameter int RW         = 16,
    parameter int ALU_MODE_W = 4,
    parameter int FLAG_CNT   = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [RW-1:0]         i_l,
    input  logic [RW-1:0]         i_r,
    input  logic [ALU_MODE_W-1:0] i_mode,
    input  logic                  i_carry,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [RW-1:0]         o_out,
    output logic [FLAG_CNT-1:0]   o_flags
);
    localparam logic [ALU_MODE_W-1:0] M_RPASS = ALU_MODE_W'(1),  M_ADD  = ALU_MODE_W'(2),
                                      M_SUB   = ALU_MODE_W'(3),  M_AND  = ALU_MODE_W'(4),
                                      M_OR    = ALU_MODE_W'(5),  M_XOR  = ALU_MODE_W'(6),
                                      M_SHL   = ALU_MODE_W'(7),  M_SHR  = ALU_MODE_W'(8),
                                      M_MUL   = ALU_MODE_W'(9),  M_DIV  = ALU_MODE_W'(10),
                                      M_ASHR  = ALU_MODE_W'(11), M_SEXT = ALU_MODE_W'(12),
                                      M_MULH  = ALU_MODE_W'(13), M_MOD  = ALU_MODE_W'(14);
    localparam int CW = $clog2(RW) + 1;
    localparam logic [RW-1:0] RW_V = RW[RW-1:0];

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    state_t state, state_nxt;

    logic [RW-1:0] a, b, opnd;
    logic [CW-1:0] cnt;
    logic          hi_op, div0;

    logic accept, is_mul, is_div, last;
    assign is_mul = (i_mode == M_MUL) || (i_mode == M_MULH);
    assign is_div = (i_mode == M_DIV) || (i_mode == M_MOD);
    assign accept = i_valid && o_ready && !i_flush;
    assign last   = (cnt == CW'(RW - 1));

    function automatic logic [FLAG_CNT-1:0] mk_flags(input logic [RW-1:0] v, input logic c, input logic o);
        logic [FLAG_CNT-1:0] f;
        f    = '0;
        f[0] = ~|v;
        f[1] = c;
        f[2] = v[RW-1];
        f[3] = o;
        f[4] = ^v;
        return f;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept && is_mul)      state_nxt = S_MUL;
                         else if (accept && is_div) state_nxt = S_DIV;
                S_MUL,
                S_DIV:   if (last) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready = (state == S_IDLE);
    end

    // Single-cycle datapath; the extra bit in each shift vector catches the last bit shifted out.
    logic [RW:0]   add_s, sub_s, shl_s, shr_s, ashr_s;
    logic [RW-1:0] sc_out;
    logic          sc_c, sc_o;
    always_comb begin
        add_s  = {1'b0, i_l} + {1'b0, i_r} + (RW+1)'(i_carry);
        sub_s  = {1'b0, i_l} - {1'b0, i_r} - (RW+1)'(i_carry);
        shl_s  = {1'b0, i_l} << i_r;
        shr_s  = {i_l, 1'b0} >> i_r;
        ashr_s = $signed({i_l, 1'b0}) >>> i_r;
        sc_out = i_l;
        sc_c   = 1'b0;
        sc_o   = 1'b0;
        case (i_mode)
            M_RPASS: sc_out = i_r;
            M_ADD: begin
                {sc_c, sc_out} = add_s;
                sc_o = ~(i_l[RW-1] ^ i_r[RW-1]) & (i_l[RW-1] ^ add_s[RW-1]);
            end
            M_SUB: begin
                {sc_c, sc_out} = sub_s;
                sc_o = (i_l[RW-1] ^ i_r[RW-1]) & (i_l[RW-1] ^ sub_s[RW-1]);
            end
            M_AND:  sc_out = i_l & i_r;
            M_OR:   sc_out = i_l | i_r;
            M_XOR:  sc_out = i_l ^ i_r;
            M_SHL:  {sc_c, sc_out} = shl_s;
            M_SHR:  {sc_out, sc_c} = shr_s;
            M_ASHR: begin
                sc_out = ashr_s[RW:1];
                sc_c   = (i_r > RW_V) ? 1'b0 : ashr_s[0];
            end
            M_SEXT: sc_out = {{(RW-8){i_l[7]}}, i_l[7:0]};
            default: ;
        endcase
    end

    // One iteration step: shift-add multiply {a,b} or restoring divide (a = remainder, b = dividend/quotient).
    logic [RW:0]   mul_sum, div_rs, div_diff;
    logic [RW-1:0] a_nxt, b_nxt, it_out;
    logic          it_c;
    always_comb begin
        mul_sum  = {1'b0, a} + (b[0] ? {1'b0, opnd} : '0);
        div_rs   = {a, b[RW-1]};
        div_diff = div_rs - {1'b0, opnd};
        if (state == S_MUL) begin
            a_nxt = mul_sum[RW:1];
            b_nxt = {mul_sum[0], b[RW-1:1]};
            it_c  = |a_nxt;
        end else begin
            a_nxt = div_diff[RW] ? div_rs[RW-1:0] : div_diff[RW-1:0];
            b_nxt = {b[RW-2:0], ~div_diff[RW]};
            it_c  = div0;
        end
        it_out = hi_op ? a_nxt : b_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a       <= '0;
            b       <= '0;
            opnd    <= '0;
            cnt     <= '0;
            hi_op   <= 1'b0;
            div0    <= 1'b0;
            o_valid <= 1'b0;
            o_out   <= '0;
            o_flags <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            cnt     <= '0;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                if (is_mul || is_div) begin
                    a     <= '0;
                    b     <= i_l;
                    opnd  <= i_r;
                    cnt   <= '0;
                    hi_op <= (i_mode == M_MULH) || (i_mode == M_MOD);
                    div0  <= (i_r == '0);
                end else begin
                    o_out   <= sc_out;
                    o_flags <= mk_flags(sc_out, sc_c, sc_o);
                    o_valid <= 1'b1;
                end
            end else if (state != S_IDLE) begin
                a   <= a_nxt;
                b   <= b_nxt;
                cnt <= cnt + 1'b1;
                if (last) begin
                    o_out   <= it_out;
                    o_flags <= mk_flags(it_out, it_c, 1'b0);
                    o_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter (RW=16): hand-computed results, flags and handshake timing.
module tb_alu_iter;
    logic        clk = 0, rst = 0, valid = 0, carry = 0, flush = 0;
    logic [15:0] l = 0, r = 0;
    logic [3:0]  mode = 0;
    logic        ready, ov;
    logic [15:0] out;
    logic [4:0]  flags;
    int checks = 0, errors = 0;
    int bad;

    always #5 clk = ~clk;

    alu_iter #(.RW(16), .ALU_MODE_W(4), .FLAG_CNT(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
        .i_l(l), .i_r(r), .i_mode(mode), .i_carry(carry), .i_flush(flush),
        .o_valid(ov), .o_out(out), .o_flags(flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags: bit0 Z, bit1 C, bit2 N, bit3 O, bit4 P.
    task automatic run(input string tag, input logic [3:0] m, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] eo, input logic [4:0] ef);
        int  nbad;
        bit  iter;
        nbad = 0;
        iter = (m == 4'd9) || (m == 4'd10) || (m == 4'd13) || (m == 4'd14);
        @(negedge clk);
        mode = m; l = a; r = b; carry = c; valid = 1;
        @(posedge clk); #1;
        valid = 0;
        if (iter) begin
            if (ov || ready) nbad++;
            for (int i = 1; i <= 15; i++) begin
                @(negedge clk);
                valid = i[0];
                @(posedge clk); #1;
                if (ov || ready) nbad++;
            end
            @(negedge clk);
            valid = 0;
            @(posedge clk); #1;
            chk({tag, " busy"}, nbad, 0);
        end
        chk({tag, " vld"}, ov, 1);
        chk({tag, " out"}, out, eo);
        chk({tag, " flags"}, flags, ef);
        chk({tag, " rdy"}, ready, 1);
        @(posedge clk); #1;
        chk({tag, " strobe"}, ov, 0);
    endtask

    initial begin
        #1 rst = 1;
        #2;
        chk("rst out", out, 16'h0);
        chk("rst flags", flags, 5'h0);
        chk("rst vld", ov, 0);
        chk("rst rdy", ready, 1);
        @(negedge clk);
        rst = 0;

        run("add_wrap",  4'd2,  16'hFFFF, 16'h0001, 0, 16'h0000, 5'h03);
        run("add_cin",   4'd2,  16'h0001, 16'h0002, 1, 16'h0004, 5'h10);
        run("sub_ovf",   4'd3,  16'h8000, 16'h0001, 0, 16'h7FFF, 5'h18);
        run("sub_borrow",4'd3,  16'h0000, 16'h0001, 0, 16'hFFFF, 5'h06);
        run("shl16",     4'd7,  16'h0001, 16'd16,   0, 16'h0000, 5'h03);
        run("shr1",      4'd8,  16'h8001, 16'd1,    0, 16'h4000, 5'h12);
        run("ashr20",    4'd11, 16'h8000, 16'd20,   0, 16'hFFFF, 5'h04);
        run("sext",      4'd12, 16'h0080, 16'h0000, 0, 16'hFF80, 5'h14);
        run("and",       4'd4,  16'hF0F0, 16'h0FF0, 0, 16'h00F0, 5'h00);

        // Back-to-back single-cycle accepts.
        @(negedge clk);
        mode = 4'd6; l = 16'hF0F0; r = 16'h0FF0; valid = 1;
        @(posedge clk); #1;
        chk("b2b xor vld", ov, 1);
        chk("b2b xor out", out, 16'hFF00);
        chk("b2b xor flags", flags, 5'h04);
        @(negedge clk);
        mode = 4'd5; l = 16'h00F0; r = 16'h0F00;
        @(posedge clk); #1;
        valid = 0;
        chk("b2b or vld", ov, 1);
        chk("b2b or out", out, 16'h0FF0);

        run("mul",       4'd9,  16'd300,  16'd300,  0, 16'h5F90, 5'h02);
        run("mulh",      4'd13, 16'd300,  16'd300,  0, 16'h0001, 5'h12);
        run("mod_div0",  4'd14, 16'h1234, 16'h0000, 0, 16'h1234, 5'h12);
        run("div_div0",  4'd10, 16'h1234, 16'h0000, 0, 16'hFFFF, 5'h06);
        run("mod",       4'd14, 16'd1000, 16'd7,    0, 16'h0006, 5'h00);
        run("div",       4'd10, 16'd1000, 16'd7,    0, 16'h008E, 5'h00);

        // Flush five cycles into a divide.
        @(negedge clk);
        mode = 4'd10; l = 16'h1234; r = 16'd3; valid = 1;
        @(posedge clk); #1;
        valid = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush vld", ov, 0);
        chk("flush rdy", ready, 1);
        chk("flush out", out, 16'h008E);
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov) bad++;
        end
        chk("flush no result", bad, 0);

        // Flush blocks a same-cycle request.
        @(negedge clk);
        flush = 1; valid = 1; mode = 4'd2; l = 16'd1; r = 16'd1;
        @(posedge clk); #1;
        flush = 0; valid = 0;
        chk("flush+req vld", ov, 0);
        chk("flush+req out", out, 16'h008E);

        // Async reset mid-multiply.
        @(negedge clk);
        mode = 4'd9; l = 16'd300; r = 16'd300; valid = 1;
        @(posedge clk); #1;
        valid = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        chk("midrst out", out, 16'h0);
        chk("midrst flags", flags, 5'h0);
        chk("midrst vld", ov, 0);
        chk("midrst rdy", ready, 1);
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov) bad++;
        end
        chk("midrst no result", bad, 0);
        run("mul_after_rst", 4'd9, 16'd300, 16'd300, 0, 16'h5F90, 5'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
